// File: rtl/uart_pkg.sv
// Shared types and constants for the 32-bit UART word receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        s_IDLE      = 3'd0,
        s_START     = 3'd1,
        s_DATA      = 3'd2,
        s_STOP      = 3'd3,
        s_WAIT_NEXT = 3'd4
    } uart_rx_state_t;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
    localparam int UART_WORD_W               = 32;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a previous-value flop
// used to detect the falling (start) edge. All flops idle high so reset
// never looks like a start edge.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next-state of the shift chain: pin -> meta -> sync -> prev.
    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Chain registers, reset to the idle-high line level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q;
    assign o_fall  = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_word.sv
// Receives four back-to-back 8N1 frames, least-significant byte first,
// and presents them as one 32-bit word with a single-cycle o_Rx_DV.
// Optional inter-byte timeout is compiled in with `define UART_RX_TIMEOUT_EN.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_n,
    input  logic                   i_Rx_Serial,
    output logic                   o_Rx_DV,
    output logic [UART_WORD_W-1:0] o_Rx_Word,
    output logic                   o_Rx_Active,
    output logic                   o_Rx_Frame_Err,
    output logic                   o_Rx_Timeout
);

    localparam logic [2:0] ST_IDLE      = s_IDLE;
    localparam logic [2:0] ST_START     = s_START;
    localparam logic [2:0] ST_DATA      = s_DATA;
    localparam logic [2:0] ST_STOP      = s_STOP;
    localparam logic [2:0] ST_WAIT_NEXT = s_WAIT_NEXT;

    localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);

    logic rx_level;
    logic rx_fall;

    logic [2:0]             state_q, state_d;
    logic [15:0]            clk_cnt_q, clk_cnt_d;
    logic [4:0]             bit_idx_q, bit_idx_d;
    logic [UART_WORD_W-1:0] rx_word_q, rx_word_d;
    logic [UART_WORD_W-1:0] out_word_q, out_word_d;
    logic                   active_q, active_d;
    logic                   dv_q, dv_d;
    logic                   ferr_q, ferr_d;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TOUT_W      = $clog2(TOUT_CYCLES);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_CYCLES - 1);

    logic [TOUT_W-1:0] tout_cnt_q, tout_cnt_d;
    logic              tout_q, tout_d;
`endif

    uart_rx_sync u_sync (
        .i_clk   (i_Clock),
        .i_rst_n (i_Rst_n),
        .i_async (i_Rx_Serial),
        .o_level (rx_level),
        .o_fall  (rx_fall)
    );

    // Receive FSM: start-bit qualification, mid-bit sampling, byte/word sequencing.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q + 16'd1;
        bit_idx_d  = bit_idx_q;
        rx_word_d  = rx_word_q;
        out_word_d = out_word_q;
        active_d   = active_q;
        dv_d       = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
        tout_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (rx_fall) begin
                    active_d = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (clk_cnt_q == HALF_BIT) begin
                    clk_cnt_d = '0;
                    if (!rx_level) begin
                        state_d = ST_DATA;
                    end else begin
                        // Glitch: a start bit that did not last half a bit.
                        // Anywhere in the word this drops the partial word.
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == FULL_BIT) begin
                    clk_cnt_d            = '0;
                    rx_word_d[bit_idx_q] = rx_level;
                    if (bit_idx_q[2:0] == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == FULL_BIT) begin
                    clk_cnt_d = '0;
                    if (rx_level) begin
                        if (bit_idx_q == 5'd31) begin
                            out_word_d = rx_word_q;
                            dv_d       = 1'b1;
                            active_d   = 1'b0;
                            state_d    = ST_IDLE;
                        end else begin
                            bit_idx_d = bit_idx_q + 5'd1;
                            state_d   = ST_WAIT_NEXT;
                        end
                    end else begin
                        ferr_d   = 1'b1;
                        active_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_WAIT_NEXT: begin
                clk_cnt_d = '0;
                if (rx_fall) begin
                    state_d = ST_START;
                end
`ifdef UART_RX_TIMEOUT_EN
                else if (tout_cnt_q == TOUT_LAST) begin
                    tout_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end
`endif
            end
            default: begin
                clk_cnt_d = '0;
                active_d  = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset returns everything to idle.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            out_word_q <= '0;
            active_q   <= 1'b0;
            dv_q       <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            out_word_q <= out_word_d;
            active_q   <= active_d;
            dv_q       <= dv_d;
            ferr_q     <= ferr_d;
        end
    end

    // Assembly shift target; every bit is rewritten before it is published.
    always_ff @(posedge i_Clock) begin
        rx_word_q <= rx_word_d;
    end

`ifdef UART_RX_TIMEOUT_EN
    // Inter-byte gap counter, running only while waiting for the next start edge.
    always_comb begin
        if (state_q == ST_WAIT_NEXT && state_d == ST_WAIT_NEXT) begin
            tout_cnt_d = tout_cnt_q + TOUT_W'(1);
        end else begin
            tout_cnt_d = '0;
        end
    end

    // Timeout counter and pulse registers.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tout_cnt_q <= '0;
            tout_q     <= 1'b0;
        end else begin
            tout_cnt_q <= tout_cnt_d;
            tout_q     <= tout_d;
        end
    end

    assign o_Rx_Timeout = tout_q;
`else
    assign o_Rx_Timeout = 1'b0;
`endif

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Word      = out_word_q;
    assign o_Rx_Active    = active_q;
    assign o_Rx_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word at CLKS_PER_BIT=16, TIMEOUT_BITS=4.
// Builds with or without `define UART_RX_TIMEOUT_EN.
module tb_uart_rx_word;

    localparam int CPB = 16;

    localparam int EV_DV   = 1;
    localparam int EV_FERR = 2;
    localparam int EV_TOUT = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx    = 1'b1;
    logic        o_Rx_DV;
    logic [31:0] o_Rx_Word;
    logic        o_Rx_Active;
    logic        o_Rx_Frame_Err;
    logic        o_Rx_Timeout;

    typedef struct {
        int          kind;
        logic [31:0] word;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks   = 0;
    int          n_errors   = 0;
    logic [31:0] model_word = 32'h0;

    uart_rx_word #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (4)
    ) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (o_Rx_DV),
        .o_Rx_Word      (o_Rx_Word),
        .o_Rx_Active    (o_Rx_Active),
        .o_Rx_Frame_Err (o_Rx_Frame_Err),
        .o_Rx_Timeout   (o_Rx_Timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Model-based compare, once per cycle away from the active edge.
    always @(negedge clk) begin
        ev_t e;
        int  kind_now;
        if (!rst_n) begin
            check("reset_pulses_active",
                  32'({o_Rx_DV, o_Rx_Frame_Err, o_Rx_Timeout, o_Rx_Active}), 32'h0);
            check("reset_word", o_Rx_Word, 32'h0);
            model_word = 32'h0;
            exp_q.delete();
        end else begin
            if (o_Rx_DV || o_Rx_Frame_Err || o_Rx_Timeout) begin
                check("pulse_exclusive",
                      32'(o_Rx_DV) + 32'(o_Rx_Frame_Err) + 32'(o_Rx_Timeout), 32'd1);
                check("active_low_at_end", 32'(o_Rx_Active), 32'd0);
                kind_now = o_Rx_DV ? EV_DV : (o_Rx_Frame_Err ? EV_FERR : EV_TOUT);
                check("event_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(kind_now), 32'(e.kind));
                    if (e.kind == EV_DV && kind_now == EV_DV) begin
                        model_word = e.word;
                    end
                end
            end
            check("word_hold", o_Rx_Word, model_word);
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back(ev_t'{kind: EV_DV, word: w});
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], 1'b1);
            if (k == 0) check("active_mid_word", 32'(o_Rx_Active), 32'd1);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("por_word", o_Rx_Word, 32'h0);
        check("por_active", 32'(o_Rx_Active), 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Basic word, bytes 78 56 34 12.
        send_word(32'h12345678);
        idle(20);
        wait_drain("drain_word1");
        check("word1_literal", o_Rx_Word, 32'h12345678);
        check("active_after_word1", 32'(o_Rx_Active), 32'd0);

        // Two words with zero idle between them.
        send_word(32'hDEADBEEF);
        send_word(32'h00000001);
        idle(20);
        wait_drain("drain_b2b");
        check("b2b_literal", o_Rx_Word, 32'h00000001);

        // Stop bit of byte 1 low: frame error, word kept.
        exp_q.push_back(ev_t'{kind: EV_FERR, word: 32'h0});
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle(40);
        wait_drain("drain_ferr");
        check("word_after_ferr", o_Rx_Word, 32'h00000001);
        check("active_after_ferr", 32'(o_Rx_Active), 32'd0);
        send_word(32'hA5A5A5A5);
        idle(20);
        wait_drain("drain_after_ferr");
        check("a5_literal", o_Rx_Word, 32'hA5A5A5A5);

        // 6-cycle glitch on an idle line.
        rx = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rx = 1'b1;
        idle(40);
        check("active_after_glitch", 32'(o_Rx_Active), 32'd0);
        check("word_after_glitch", o_Rx_Word, 32'hA5A5A5A5);
        send_word(32'h5AC3E719);
        idle(20);
        wait_drain("drain_after_glitch");
        check("glitch_next_literal", o_Rx_Word, 32'h5AC3E719);

`ifdef UART_RX_TIMEOUT_EN
        // Long gap after byte 0 times out.
        exp_q.push_back(ev_t'{kind: EV_TOUT, word: 32'h0});
        send_byte(8'h11, 1'b1);
        idle(100);
        wait_drain("drain_timeout");
        check("active_after_timeout", 32'(o_Rx_Active), 32'd0);
        check("word_after_timeout", o_Rx_Word, 32'h5AC3E719);
`else
        // Long gap after byte 0 is tolerated.
        exp_q.push_back(ev_t'{kind: EV_DV, word: 32'h44332211});
        send_byte(8'h11, 1'b1);
        idle(200);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(20);
        wait_drain("drain_gap_word");
        check("gap_word_literal", o_Rx_Word, 32'h44332211);
`endif

        // Reset asserted during byte 2.
        send_byte(8'h0D, 1'b1);
        send_byte(8'hF0, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midword_reset_word", o_Rx_Word, 32'h0);
        check("midword_reset_active", 32'(o_Rx_Active), 32'd0);
        rst_n = 1'b1;
        idle(20);
        send_word(32'hCAFEF00D);
        idle(20);
        wait_drain("drain_after_reset");
        check("cafe_literal", o_Rx_Word, 32'hCAFEF00D);

        idle(10);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
